// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline enable/flush control for the 5-stage RV32 core.
// Resolves hazards in the fixed order data-memory wait > EX redirect > load-use.
// A wait-timeout FSM halts the core when the data bus hangs, and two saturating
// counters record stall cycles and redirect flushes for debug.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_redirect,
  input  logic             ex_mem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // wait_cnt must be able to hold values up to TIMEOUT.
  localparam int WC_W = $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(TIMEOUT - 1);
  localparam logic [WC_W-1:0]  WAIT_ONE  = WC_W'(1);
  localparam logic [WC_W-1:0]  WAIT_ZERO = WC_W'(0);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             halted_q, halted_d;
  logic             mem_fault_q, mem_fault_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic [CNT_W-1:0] flush_count_q, flush_count_d;

  logic mem_stall_s;
  logic load_use_s;
  logic rs1_match_s;
  logic rs2_match_s;
  logic stall_act_s;
  logic flush_act_s;

  // Raw hazard terms decoded from the pipeline-register fields.
  always_comb begin
    rs1_match_s = id_uses_rs1 & (id_rs1 == id_ex_rd);
    rs2_match_s = id_uses_rs2 & (id_rs2 == id_ex_rd);
    mem_stall_s = ex_mem_mem_req & ~dmem_ready;
    // x0 is never a real producer, so a load targeting it causes no hazard.
    load_use_s  = id_ex_mem_read & (id_ex_rd != 5'd0) & (rs1_match_s | rs2_match_s);
  end

  // Per-stage enables and flushes, combinational so they act on the next edge.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_en     = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_en    = 1'b1;
    mem_wb_flush = 1'b0;
    stall_act_s  = 1'b0;
    flush_act_s  = 1'b0;
    if (rst) begin
      // Hold the whole pipe frozen and bubbled while reset is asserted.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (state_q == ST_HALT) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_en     = 1'b0;
      id_ex_flush  = 1'b1;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mem_stall_s) begin
      // Freeze everything upstream of MEM; redirect/load-use inputs stay
      // stable because their producing stages are frozen too.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      stall_act_s  = 1'b1;
    end else if (ex_redirect) begin
      // PC loads the branch target; the two younger fetched slots are killed.
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      flush_act_s  = 1'b1;
    end else if (load_use_s) begin
      // Hold IF and ID one cycle and inject a single bubble into EX.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_flush  = 1'b1;
      stall_act_s  = 1'b1;
    end else begin
      stall_act_s  = 1'b0;
    end
  end

  // Memory-wait FSM: counts consecutive stalled cycles and halts on timeout.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_s) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_ZERO;
        end
      end
      ST_WAIT: begin
        if (mem_stall_s) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_HALT;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end else begin
          // Either the access completed or the request was withdrawn.
          state_d    = ST_RUN;
          wait_cnt_d = WAIT_ZERO;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = WAIT_ZERO;
      end
    endcase
  end

  // Status flags and saturating debug counters; all frozen once halted.
  always_comb begin
    halted_d      = (state_d == ST_HALT);
    mem_fault_d   = (state_d == ST_HALT) && (state_q != ST_HALT);
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (state_q != ST_HALT) begin
      if (stall_act_s && (stall_count_q != CNT_MAX)) begin
        stall_count_d = stall_count_q + CNT_ONE;
      end else begin
        stall_count_d = stall_count_q;
      end
      if (flush_act_s && (flush_count_q != CNT_MAX)) begin
        flush_count_d = flush_count_q + CNT_ONE;
      end else begin
        flush_count_d = flush_count_q;
      end
    end else begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
    end
  end

  // State, wait counter, flags and counters, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= WAIT_ZERO;
      halted_q      <= 1'b0;
      mem_fault_q   <= 1'b0;
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      halted_q      <= halted_d;
      mem_fault_q   <= mem_fault_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign halted      = halted_q;
  assign mem_fault   = mem_fault_q;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a stimulus process drives inputs and pushes
// the reference model's expected outputs; a monitor pops and compares.
module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1 = 5'd0, id_rs2 = 5'd0, id_ex_rd = 5'd0;
  logic             id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_ex_mem_read = 1'b0;
  logic             ex_redirect = 1'b0, ex_mem_mem_req = 1'b0, dmem_ready = 1'b0;
  logic             pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush;
  logic             halted, mem_fault;
  logic [CNT_W-1:0] stall_count, flush_count;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
    .ex_redirect(ex_redirect), .ex_mem_mem_req(ex_mem_mem_req), .dmem_ready(dmem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
    .mem_wb_flush(mem_wb_flush), .halted(halted), .mem_fault(mem_fault),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] ctl;   // {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,mem_wb_flush}
    logic       halted;
    logic       fault;
    int         stall;
    int         flush;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state: run length of consecutive memory-stall cycles,
  // sticky halt, fault pulse and plain integer counters.
  int   m_run_len = 0;
  bit   m_halted = 1'b0;
  bit   m_fault = 1'b0;
  int   m_stall = 0;
  int   m_flush = 0;

  task automatic model_push();
    exp_t e;
    bit ms, lu, e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmemen, e_mwbfl, redir_applied;
    if (rst) begin
      m_run_len = 0; m_halted = 1'b0; m_fault = 1'b0; m_stall = 0; m_flush = 0;
    end
    ms = ex_mem_mem_req && !dmem_ready;
    lu = id_ex_mem_read && (id_ex_rd != 5'd0) &&
         ((id_uses_rs1 && (id_rs1 == id_ex_rd)) || (id_uses_rs2 && (id_rs2 == id_ex_rd)));
    e_pc = 1; e_ifen = 1; e_iffl = 0; e_idexen = 1; e_idexfl = 0; e_exmemen = 1; e_mwbfl = 0;
    redir_applied = 0;
    if (rst || m_halted) begin
      e_pc = 0; e_ifen = 0; e_iffl = 1; e_idexen = 0; e_idexfl = 1; e_exmemen = 0; e_mwbfl = 1;
    end else if (ms) begin
      e_pc = 0; e_ifen = 0; e_idexen = 0; e_exmemen = 0; e_mwbfl = 1;
    end else if (ex_redirect) begin
      e_iffl = 1; e_idexfl = 1; redir_applied = 1;
    end else if (lu) begin
      e_pc = 0; e_ifen = 0; e_idexfl = 1;
    end
    e.ctl    = {e_pc, e_ifen, e_iffl, e_idexen, e_idexfl, e_exmemen, e_mwbfl};
    e.halted = m_halted;
    e.fault  = m_fault;
    e.stall  = m_stall;
    e.flush  = m_flush;
    sb_q.push_back(e);
    // Advance the model across the coming rising edge.
    if (!rst) begin
      if (!m_halted) begin
        if (!e_pc && m_stall < CMAX) m_stall++;
        if (redir_applied && m_flush < CMAX) m_flush++;
        m_run_len = ms ? m_run_len + 1 : 0;
        if (m_run_len >= TIMEOUT) begin
          m_halted = 1'b1;
          m_fault  = 1'b1;
        end else begin
          m_fault  = 1'b0;
        end
      end else begin
        m_fault = 1'b0;
      end
    end
  endtask

  task automatic apply(input logic a_rst, input logic [4:0] a_rs1, input logic [4:0] a_rs2,
                       input logic a_u1, input logic a_u2, input logic [4:0] a_rd,
                       input logic a_mr, input logic a_redir, input logic a_req, input logic a_rdy);
    @(posedge clk);
    #1;
    rst = a_rst; id_rs1 = a_rs1; id_rs2 = a_rs2; id_uses_rs1 = a_u1; id_uses_rs2 = a_u2;
    id_ex_rd = a_rd; id_ex_mem_read = a_mr; ex_redirect = a_redir;
    ex_mem_mem_req = a_req; dmem_ready = a_rdy;
    #1;
    model_push();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        act = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_flush};
        if (act !== e.ctl) begin
          miscompares++;
          $display("FAIL ctl vec=%0d got=%b want=%b", vectors, act, e.ctl);
        end
        if (halted !== e.halted) begin
          miscompares++;
          $display("FAIL halted vec=%0d got=%b want=%b", vectors, halted, e.halted);
        end
        if (mem_fault !== e.fault) begin
          miscompares++;
          $display("FAIL mem_fault vec=%0d got=%b want=%b", vectors, mem_fault, e.fault);
        end
        if ($isunknown(stall_count) || int'(stall_count) != e.stall) begin
          miscompares++;
          $display("FAIL stall_count vec=%0d got=%0d want=%0d", vectors, stall_count, e.stall);
        end
        if ($isunknown(flush_count) || int'(flush_count) != e.flush) begin
          miscompares++;
          $display("FAIL flush_count vec=%0d got=%0d want=%0d", vectors, flush_count, e.flush);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by biased random traffic.
  initial begin
    // Reset state.
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    // Load-use on rs2, then the same with rd = x0 (no stall).
    apply(1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    apply(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    // Load-use on rs1 with rs1 unused: no stall.
    apply(1'b0, 5'd7, 5'd2, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    // Redirect together with load-use.
    apply(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1);
    // Memory wait of 3 cycles with a redirect held, then ready.
    for (int i = 0; i < 3; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(1);
    // Timeout into HALT, stay halted, then reset during HALT.
    for (int i = 0; i < TIMEOUT + 3; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    // Reset during WAIT, then a wait that ends by dropping the request.
    for (int i = 0; i < 2; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Saturation: 20 load-use stalls.
    for (int i = 0; i < 20; i++) apply(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1);
    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 79) == 0),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0));
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got=%0d left want=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage RV32 core. It produces the per-stage enable and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard sources by fixed priority: data-memory wait, control redirect from EX, and load-use. A wait-timeout FSM halts the core on a hung data bus, and saturating counters record stall and flush activity for debug.

## Interface
Parameters:
- TIMEOUT, 64: consecutive memory-wait cycles before fault; legal range 2..65535.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- id_ex_rd  in  5  destination register held in ID/EX.
- id_ex_mem_read  in  1  the ID/EX instruction is a load.
- ex_redirect  in  1  taken branch or jump resolved in EX this cycle.
- ex_mem_mem_req  in  1  the EX/MEM instruction performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC register load enable.
- if_id_en  out  1  IF/ID hold enable (0 = hold).
- if_id_flush  out  1  IF/ID clears to bubble.
- id_ex_en  out  1  ID/EX hold enable.
- id_ex_flush  out  1  ID/EX clears to bubble.
- ex_mem_en  out  1  EX/MEM hold enable.
- mem_wb_flush  out  1  MEM/WB loads a bubble.
- halted  out  1  core halted after a bus timeout.
- mem_fault  out  1  one-cycle pulse on entering HALT.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of redirect flushes.

## Operation
- Internal terms:
  - mem_stall = ex_mem_mem_req & ~dmem_ready.
  - load_use = id_ex_mem_read & (id_ex_rd != 0) & ((id_uses_rs1 & id_rs1 == id_ex_rd) | (id_uses_rs2 & id_rs2 == id_ex_rd)).
- FSM states are RUN, WAIT and HALT.
- Default output values: all enables 1, all flushes 0.
- Priority, evaluated in RUN or WAIT:
  1. mem_stall: pc_en = if_id_en = id_ex_en = ex_mem_en = 0 and mem_wb_flush = 1. Redirect and load-use are ignored; they stay stable because their stages are frozen.
  2. ex_redirect: if_id_flush = id_ex_flush = 1 and pc_en = 1 (PC loads the target). Load-use is ignored.
  3. load_use: pc_en = if_id_en = 0 and id_ex_flush = 1, giving exactly one bubble.
- FSM transitions:
  - RUN → WAIT when mem_stall; wait_cnt ← 1.
  - WAIT, dmem_ready = 1 → RUN; wait_cnt ← 0.
  - WAIT, mem_stall with wait_cnt == TIMEOUT−1 → HALT.
  - WAIT, otherwise: wait_cnt increments.
  - WAIT with ex_mem_mem_req dropped → RUN.
  - HALT is sticky until reset.
- In HALT:
  - all enables are 0 and if_id_flush, id_ex_flush, mem_wb_flush are 1.
  - halted = 1.
  - mem_fault = 1 only on the first HALT cycle.
  - counters freeze.
- stall_count increments each RUN/WAIT cycle with pc_en = 0.
- flush_count increments each cycle the redirect flush is applied (priority 2 active).
- Both counters saturate at all-ones and never wrap.
- wait_cnt width is clog2(TIMEOUT+1).

## Timing
- Enables and flushes are combinational from inputs and state, so they are valid in the same cycle as the hazard and act on the next rising edge.
- halted, mem_fault and the counters are registered.
- Load-use costs exactly 1 cycle. A redirect costs 2 flushed slots. A memory wait of N cycles freezes the pipe for N cycles; the edge with dmem_ready = 1 advances normally.
- While rst = 1:
  - state = RUN, wait_cnt = 0, counters = 0, halted = 0, mem_fault = 0.
  - all enables are forced 0 and all flushes forced 1.
- Reset asserted mid-WAIT or in HALT returns to RUN immediately (asynchronous).
- The first cycle after rst falls uses the default enables.
- The timeout fault fires on the edge ending the TIMEOUT-th consecutive stalled cycle.

## Test plan
- Load-use: id_ex_mem_read = 1, id_ex_rd = 5, id_rs2 = 5, id_uses_rs2 = 1 → one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1; stall_count 0 → 1. With id_ex_rd = 0 → no stall.
- Redirect and load-use in the same cycle → if_id_flush = id_ex_flush = 1, pc_en = 1; flush_count = 1, stall_count unchanged.
- Memory wait: ex_mem_mem_req = 1, dmem_ready low for 3 cycles, with ex_redirect = 1 also held → all enables 0 and mem_wb_flush = 1 for 3 cycles with no flush; then ready → redirect flush the next cycle; stall_count = 3.
- Timeout: TIMEOUT = 4, dmem_ready held low → HALT after the 4th stalled cycle; mem_fault pulses 1 cycle; halted stays 1; counters frozen.
- Saturation: CNT_W = 4 with 20 load-use stalls → stall_count = 15.
- Reset mid-operation: assert rst during WAIT and during HALT → asynchronous return to RUN with all outputs at reset values; normal operation after release.
